// File: rtl/addsub_accumulator_ctrl.sv
// Control stage for the 4-bit adder/subtractor: accepts operand/mode transactions,
// runs one adder cycle against the accumulator, then presents the result downstream.
module addsub_accumulator_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_operand,
  input  logic             in_mode,
  input  logic             in_clear,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_mode,
  input  logic [WIDTH-1:0] add_result,
  input  logic             add_cout,
  input  logic             add_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_acc,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             op_mode_q, op_mode_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      op_b_q      <= '0;
      op_mode_q   <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      op_b_q      <= op_b_d;
      op_mode_q   <= op_mode_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and register updates
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    op_b_d    = op_b_q;
    op_mode_d = op_mode_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    sticky_d  = sticky_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          if (in_clear) begin
            acc_d    = '0;
            cout_d   = 1'b0;
            ovf_d    = 1'b0;
            sticky_d = 1'b0;
            cnt_d    = '0;
            state_d  = DONE;
          end else begin
            op_b_d    = in_operand;
            op_mode_d = in_mode;
            state_d   = EXEC;
          end
        end
      end
      EXEC: begin
        acc_d    = add_result;
        cout_d   = add_cout;
        ovf_d    = add_ovf;
        sticky_d = sticky_q | add_ovf;
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake flags are registered copies of the upcoming state
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign add_a      = acc_q;
  assign add_b      = op_b_q;
  assign add_mode   = op_mode_q;
  assign out_acc    = acc_q;
  assign out_cout   = cout_q;
  assign out_ovf    = ovf_q;
  assign ovf_sticky = sticky_q;
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_addsub_accumulator_ctrl.sv
// Bench for addsub_accumulator_ctrl: a behavioural adder closes the loop and a
// transaction-level accumulator model supplies the expected results.
module tb_addsub_accumulator_ctrl;

  typedef struct packed {
    logic [3:0] acc;
    logic       cout;
    logic       ovf;
    logic       sticky;
    logic [7:0] cnt;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_mode, in_clear;
  logic [3:0] in_operand;
  logic [3:0] add_a, add_b, add_result;
  logic       add_mode, add_cout, add_ovf;
  logic       out_valid, out_ready, out_cout, out_ovf, ovf_sticky;
  logic [3:0] out_acc;
  logic [7:0] op_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [3:0] acc_m;
  logic       sticky_m;
  logic [7:0] cnt_m;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  addsub_accumulator_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_operand(in_operand),
    .in_mode(in_mode), .in_clear(in_clear),
    .add_a(add_a), .add_b(add_b), .add_mode(add_mode),
    .add_result(add_result), .add_cout(add_cout), .add_ovf(add_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_cout(out_cout), .out_ovf(out_ovf), .ovf_sticky(ovf_sticky),
    .op_count(op_count)
  );

  // Universal adder behaviour in plain integer arithmetic: {cout, ovf, result}
  function automatic logic [5:0] add_fn(input logic [3:0] a, input logic [3:0] b, input logic m);
    int ua, ub, sa, sb, s, sr;
    logic co, ov;
    ua = int'(a);
    ub = int'(b);
    sa = (ua > 7) ? ua - 16 : ua;
    sb = (ub > 7) ? ub - 16 : ub;
    if (!m) begin
      s = ua + ub; co = (s > 15); sr = sa + sb;
    end else begin
      s = ua - ub; co = (ua >= ub); sr = sa - sb;
    end
    ov = (sr > 7) || (sr < -8);
    return {co, ov, 4'(s)};
  endfunction

  assign {add_cout, add_ovf, add_result} = add_fn(add_a, add_b, add_mode);

  function automatic res_t mk(input logic [3:0] a, input logic c, input logic o,
                              input logic s, input logic [7:0] n);
    res_t r;
    r.acc = a; r.cout = c; r.ovf = o; r.sticky = s; r.cnt = n;
    return r;
  endfunction

  function automatic res_t sample();
    return mk(out_acc, out_cout, out_ovf, ovf_sticky, op_count);
  endfunction

  // Transaction-level expectation of the accumulator after one operation
  function automatic res_t model_step(input logic clr, input logic [3:0] opnd, input logic mode);
    logic [5:0] t;
    if (clr) begin
      acc_m = 4'd0; sticky_m = 1'b0; cnt_m = 8'd0;
      return mk(4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    end
    t = add_fn(acc_m, opnd, mode);
    acc_m = t[3:0];
    sticky_m = sticky_m | t[4];
    if (cnt_m != 8'd255) cnt_m = cnt_m + 8'd1;
    return mk(acc_m, t[5], t[4], sticky_m, cnt_m);
  endfunction

  function automatic void model_reset();
    acc_m = 4'd0; sticky_m = 1'b0; cnt_m = 8'd0;
  endfunction

  // Drive one transaction, hold out_ready low for `delay` cycles, return the result seen
  task automatic run_op(input logic [3:0] opnd, input logic mode, input logic clr,
                        input int delay, output res_t obs, output int acc_cyc);
    int n;
    obs = '0;
    acc_cyc = -1;
    @(negedge clk);
    in_operand = opnd; in_mode = mode; in_clear = clr; in_valid = 1'b1;
    out_ready = (delay == 0);
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
      in_valid = 1'b0; out_ready = 1'b1;
      return;
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
    in_operand = 4'($urandom);
    in_mode = 1'($urandom);
    in_clear = 1'($urandom);
    @(negedge clk);
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    total++;
    if (!out_valid) begin
      bad++;
      $display("FAIL out_valid_timeout: out_valid=%b required 1", out_valid);
      out_ready = 1'b1;
      return;
    end
    repeat (delay) @(negedge clk);
    obs = sample();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_clear = 1'b0;
  endtask

  task automatic test_reset();
    logic [25:0] all_out;
    rst_n = 1'b1; in_valid = 1'b0; in_operand = 4'd0; in_mode = 1'b0;
    in_clear = 1'b0; out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #3;
    all_out = {in_ready, out_valid, out_acc, out_cout, out_ovf, ovf_sticky, op_count,
               add_a, add_b, add_mode};
    total++;
    if (all_out !== 26'd0) begin
      bad++; $display("FAIL reset_outputs: got %h required 0", all_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++; $display("FAIL reset_release: in_ready,out_valid=%b required 10", {in_ready, out_valid});
    end
    model_reset();
  endtask

  task automatic test_plan_ops();
    res_t obs, expv[3];
    int c;
    logic [3:0] opnd[3];
    logic       md[3];
    opnd = '{4'd5, 4'd3, 4'd3};
    md   = '{1'b0, 1'b0, 1'b1};
    expv = '{mk(4'd5, 1'b0, 1'b0, 1'b0, 8'd1),
             mk(4'd8, 1'b0, 1'b1, 1'b1, 8'd2),
             mk(4'd5, 1'b1, 1'b1, 1'b1, 8'd3)};
    for (int i = 0; i < 3; i++) begin
      run_op(opnd[i], md[i], 1'b0, 0, obs, c);
      void'(model_step(1'b0, opnd[i], md[i]));
      total++;
      if (obs !== expv[i]) begin
        bad++; $display("FAIL plan_op%0d: got %h required %h", i, obs, expv[i]);
      end
    end
  endtask

  task automatic test_clear();
    res_t obs, expv[3];
    int c;
    logic [3:0] opnd[3];
    logic       clr[3];
    opnd = '{4'd9, 4'd15, 4'd1};
    clr  = '{1'b1, 1'b0, 1'b0};
    expv = '{mk(4'd0, 1'b0, 1'b0, 1'b0, 8'd0),
             mk(4'd15, 1'b0, 1'b0, 1'b0, 8'd1),
             mk(4'd0, 1'b1, 1'b0, 1'b0, 8'd2)};
    for (int i = 0; i < 3; i++) begin
      run_op(opnd[i], 1'b0, clr[i], 0, obs, c);
      void'(model_step(clr[i], opnd[i], 1'b0));
      total++;
      if (obs !== expv[i]) begin
        bad++; $display("FAIL clear_seq%0d: got %h required %h", i, obs, expv[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    res_t expv, obs;
    logic [3:0] held;
    int n;
    @(negedge clk);
    in_operand = 4'd6; in_mode = 1'b0; in_clear = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    expv = model_step(1'b0, 4'd6, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    obs = sample();
    held = out_acc;
    total++;
    if (obs !== expv) begin
      bad++; $display("FAIL bp_result: got %h required %h", obs, expv);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_operand = 4'($urandom); in_mode = 1'($urandom); in_valid = 1'b1;
      total++;
      if ({out_valid, in_ready, out_acc} !== {1'b1, 1'b0, expv.acc}) begin
        bad++;
        $display("FAIL bp_hold%0d: valid,ready,acc=%b,%b,%h required 1,0,%h",
                 i, out_valid, in_ready, out_acc, expv.acc);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({out_valid, in_ready, out_acc, op_count} !== {1'b0, 1'b1, held, cnt_m}) begin
      bad++;
      $display("FAIL bp_release: valid,ready,acc,cnt=%b,%b,%h,%0d required 0,1,%h,%0d",
               out_valid, in_ready, out_acc, op_count, held, cnt_m);
    end
  endtask

  task automatic test_random(input int count);
    res_t obs, expv;
    logic [3:0] opnd;
    logic md, clr;
    int c;
    for (int i = 0; i < count; i++) begin
      opnd = 4'($urandom);
      md   = 1'($urandom);
      clr  = (($urandom % 12) == 0);
      run_op(opnd, md, clr, int'($urandom % 3), obs, c);
      expv = model_step(clr, opnd, md);
      total++;
      if (obs !== expv) begin
        bad++; $display("FAIL random%0d: got %h required %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_reset_mid();
    res_t obs, expv;
    logic [25:0] all_out;
    int c, n;
    run_op(4'd0, 1'b0, 1'b1, 0, obs, c);
    void'(model_step(1'b1, 4'd0, 1'b0));
    run_op(4'd7, 1'b0, 1'b0, 0, obs, c);
    expv = model_step(1'b0, 4'd7, 1'b0);
    total++;
    if (obs !== expv) begin
      bad++; $display("FAIL mid_setup: got %h required %h", obs, expv);
    end
    @(negedge clk);
    in_operand = 4'd2; in_mode = 1'b1; in_clear = 1'b0; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++;
    if ({add_a, add_b, add_mode} !== {4'd7, 4'd2, 1'b1}) begin
      bad++; $display("FAIL mid_exec_drive: a,b,mode=%h,%h,%b required 7,2,1", add_a, add_b, add_mode);
    end
    #1 rst_n = 1'b0;
    #1;
    all_out = {in_ready, out_valid, out_acc, out_cout, out_ovf, ovf_sticky, op_count,
               add_a, add_b, add_mode};
    total++;
    if (all_out !== 26'd0) begin
      bad++; $display("FAIL mid_reset_outputs: got %h required 0", all_out);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({out_valid, in_ready, out_acc} !== {1'b0, 1'b1, 4'd0}) begin
      bad++;
      $display("FAIL mid_after_release: valid,ready,acc=%b,%b,%h required 0,1,0",
               out_valid, in_ready, out_acc);
    end
  endtask

  task automatic test_saturate();
    res_t obs, expv;
    logic [3:0] pre;
    int c, prev;
    run_op(4'd9, 1'b0, 1'b0, 0, obs, c);
    expv = model_step(1'b0, 4'd9, 1'b0);
    total++;
    if (obs !== expv) begin
      bad++; $display("FAIL sat_setup: got %h required %h", obs, expv);
    end
    pre = acc_m;
    prev = -1;
    for (int i = 0; i < 260; i++) begin
      run_op(4'd0, 1'b0, 1'b0, 0, obs, c);
      expv = model_step(1'b0, 4'd0, 1'b0);
      total++;
      if (obs !== expv) begin
        bad++; $display("FAIL sat_op%0d: got %h required %h", i, obs, expv);
      end
      if (prev >= 0) begin
        total++;
        if (c - prev != 3) begin
          bad++; $display("FAIL sat_spacing%0d: got %0d cycles required 3", i, c - prev);
        end
      end
      prev = c;
    end
    total++;
    if ({op_count, out_acc} !== {8'd255, pre}) begin
      bad++; $display("FAIL sat_final: cnt,acc=%0d,%h required 255,%h", op_count, out_acc, pre);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_plan_ops();
    test_clear();
    test_backpressure();
    test_random(40);
    test_reset_mid();
    test_random(20);
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
